// File: rtl/mux_scan_pkg.sv
// Shared types and sizing helpers for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        PARITY = 2'd2
    } scan_state_e;

    localparam int SEL_W_DEFAULT  = 3;
    localparam int DATA_W_DEFAULT = 2 ** SEL_W_DEFAULT;

    function automatic int data_width(input int sel_w);
        return 2 ** sel_w;
    endfunction

    // Counter must hold 0..DWELL-1, sized generously to DWELL+1 codes.
    function automatic int dwell_cnt_width(input int dwell);
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/sel_mux8.sv
// Combinational DATA_W:1 bit select feeding the serial output.
module sel_mux8
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT
)(
    input  logic [data_width(SEL_W)-1:0] mux_in_i,
    input  logic [SEL_W-1:0]             sel_i,
    output logic                         bit_o
);

    assign bit_o = mux_in_i[sel_i];

endmodule

// File: rtl/mux_scan_sequencer.sv
// Captures a parallel word and walks the mux select LSB first, one beat per dwell period.
// Optional trailing even-parity beat when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT,
    parameter int DWELL = 1
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [data_width(SEL_W)-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [data_width(SEL_W)-1:0] mux_in,
    output logic [SEL_W-1:0]             sel,
    output logic                         ser_bit,
    output logic                         ser_valid,
    input  logic                         ser_ready,
    output logic                         ser_last,
    output logic                         busy
);

    localparam int                DATA_W   = data_width(SEL_W);
    localparam int                CNT_W    = dwell_cnt_width(DWELL);
    localparam logic [CNT_W-1:0]  DWELL_TC = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(DATA_W - 1);

    scan_state_e       state_q, state_d;
    logic [DATA_W-1:0] mux_in_q, mux_in_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              mux_bit;
    logic              offer;
    logic              beat_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mux_in_q <= '0;
            sel_q    <= '0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            mux_in_q <= mux_in_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
        end
    end

    assign offer     = (state_q != IDLE) && (dwell_q == DWELL_TC);
    assign beat_xfer = offer && ser_ready;

    always_comb begin
        state_d  = state_q;
        mux_in_d = mux_in_q;
        sel_d    = sel_q;
        dwell_d  = dwell_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mux_in_d = in_data;
                    sel_d    = '0;
                    dwell_d  = '0;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (beat_xfer) begin
                    dwell_d = '0;
                    if (sel_q == SEL_LAST) begin
`ifdef MUX_SCAN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        sel_d   = '0;
`endif
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else if (dwell_q != DWELL_TC) begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end

            // Select is held at the last bit while the parity beat is offered.
            PARITY: begin
                if (beat_xfer) begin
                    dwell_d = '0;
                    sel_d   = '0;
                    state_d = IDLE;
                end else if (dwell_q != DWELL_TC) begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = '0;
                dwell_d = '0;
            end
        endcase
    end

    sel_mux8 #(
        .SEL_W (SEL_W)
    ) u_sel_mux (
        .mux_in_i (mux_in_q),
        .sel_i    (sel_q),
        .bit_o    (mux_bit)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mux_in    = mux_in_q;
    assign sel       = sel_q;
    assign ser_valid = offer;

`ifdef MUX_SCAN_PARITY_EN
    assign ser_bit  = (state_q == PARITY) ? ^mux_in_q : mux_bit;
    assign ser_last = offer && (state_q == PARITY);
`else
    assign ser_bit  = mux_bit;
    assign ser_last = offer && (sel_q == SEL_LAST);
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance at DWELL=1, one at DWELL=3.
module tb_mux_scan_sequencer;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;
`ifdef MUX_SCAN_PARITY_EN
    localparam int NBEATS = DATA_W + 1;
`else
    localparam int NBEATS = DATA_W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              ser_ready;
    logic              which;

    logic              a_in_ready, a_ser_bit, a_ser_valid, a_ser_last, a_busy;
    logic [DATA_W-1:0] a_mux_in;
    logic [SEL_W-1:0]  a_sel;
    logic              b_in_ready, b_ser_bit, b_ser_valid, b_ser_last, b_busy;
    logic [DATA_W-1:0] b_mux_in;
    logic [SEL_W-1:0]  b_sel;

    mux_scan_sequencer #(.SEL_W(SEL_W), .DWELL(1)) dut_d1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid & ~which),
        .in_ready  (a_in_ready),
        .mux_in    (a_mux_in),
        .sel       (a_sel),
        .ser_bit   (a_ser_bit),
        .ser_valid (a_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (a_ser_last),
        .busy      (a_busy)
    );

    mux_scan_sequencer #(.SEL_W(SEL_W), .DWELL(3)) dut_d3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid & which),
        .in_ready  (b_in_ready),
        .mux_in    (b_mux_in),
        .sel       (b_sel),
        .ser_bit   (b_ser_bit),
        .ser_valid (b_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (b_ser_last),
        .busy      (b_busy)
    );

    logic              o_in_ready, o_ser_bit, o_ser_valid, o_ser_last, o_busy;
    logic [DATA_W-1:0] o_mux_in;
    logic [SEL_W-1:0]  o_sel;

    assign o_in_ready  = which ? b_in_ready  : a_in_ready;
    assign o_ser_bit   = which ? b_ser_bit   : a_ser_bit;
    assign o_ser_valid = which ? b_ser_valid : a_ser_valid;
    assign o_ser_last  = which ? b_ser_last  : a_ser_last;
    assign o_busy      = which ? b_busy      : a_busy;
    assign o_mux_in    = which ? b_mux_in    : a_mux_in;
    assign o_sel       = which ? b_sel       : a_sel;

    int nvec = 0;
    int nerr = 0;

    task automatic select_dut(input logic w);
        which = w;
        @(negedge clk);
    endtask

    // Sends one word to the selected instance and checks every cycle of its scan.
    task automatic scan_word(input logic [DATA_W-1:0] data, input int dwell,
                             input int stall_beat, input int stall_len,
                             input logic pulse, input logic [DATA_W-1:0] pulse_data);
        int               cyc;
        int               last_cyc;
        int               exp_last_cyc;
        logic             exp_bit;
        logic             exp_lst;
        logic [SEL_W-1:0] exp_sel;

        nvec++;
        if (o_in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL accept_ready: in_ready=%b expected 1", o_in_ready);
        end
        in_data  = data;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 1;
        last_cyc = -1;

        for (int b = 0; b < NBEATS; b++) begin
            exp_sel = (b < DATA_W) ? SEL_W'(b) : SEL_W'(DATA_W - 1);
            exp_bit = (b < DATA_W) ? data[b] : ^data;
            exp_lst = (b == NBEATS - 1);
            for (int d = 0; d < dwell - 1; d++) begin
                nvec++;
                if (o_ser_valid !== 1'b0 || o_busy !== 1'b1 || o_in_ready !== 1'b0 || o_sel !== exp_sel) begin
                    nerr++;
                    $display("FAIL dwell_gap beat %0d: valid=%b busy=%b in_ready=%b sel=%0d expected 0 1 0 %0d",
                             b, o_ser_valid, o_busy, o_in_ready, o_sel, exp_sel);
                end
                if (pulse && b == 2 && d == 0) begin
                    in_data  = pulse_data;
                    in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
                cyc++;
            end
            nvec++;
            if (o_ser_valid !== 1'b1 || o_sel !== exp_sel || o_ser_bit !== exp_bit ||
                o_ser_last !== exp_lst || o_in_ready !== 1'b0 || o_busy !== 1'b1) begin
                nerr++;
                $display("FAIL beat %0d: valid=%b sel=%0d bit=%b last=%b in_ready=%b busy=%b expected 1 %0d %b %b 0 1",
                         b, o_ser_valid, o_sel, o_ser_bit, o_ser_last, o_in_ready, o_busy,
                         exp_sel, exp_bit, exp_lst);
            end
            if (b == NBEATS - 1) last_cyc = cyc;
            if (b == stall_beat) begin
                ser_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    cyc++;
                    nvec++;
                    if (o_ser_valid !== 1'b1 || o_sel !== exp_sel || o_ser_bit !== exp_bit || o_ser_last !== exp_lst) begin
                        nerr++;
                        $display("FAIL stall %0d beat %0d: valid=%b sel=%0d bit=%b last=%b expected 1 %0d %b %b",
                                 s, b, o_ser_valid, o_sel, o_ser_bit, o_ser_last, exp_sel, exp_bit, exp_lst);
                    end
                end
                ser_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end

        nvec++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_sel !== '0 || o_ser_valid !== 1'b0 ||
            o_ser_last !== 1'b0 || o_mux_in !== data) begin
            nerr++;
            $display("FAIL word_end: in_ready=%b busy=%b sel=%0d valid=%b last=%b mux_in=%h expected 1 0 0 0 0 %h",
                     o_in_ready, o_busy, o_sel, o_ser_valid, o_ser_last, o_mux_in, data);
        end
        exp_last_cyc = NBEATS * dwell + ((stall_beat >= 0 && stall_beat < NBEATS - 1) ? stall_len : 0);
        nvec++;
        if (last_cyc != exp_last_cyc) begin
            nerr++;
            $display("FAIL last_latency: last beat at cycle %0d expected %0d", last_cyc, exp_last_cyc);
        end
    endtask

    task automatic test_reset();
        which     = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        ser_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (a_in_ready !== 1'b1 || a_sel !== '0 || a_mux_in !== '0 || a_ser_valid !== 1'b0 ||
            a_busy !== 1'b0 || a_ser_last !== 1'b0 || a_ser_bit !== 1'b0) begin
            nerr++;
            $display("FAIL reset_d1: in_ready=%b sel=%0d mux_in=%h valid=%b busy=%b last=%b bit=%b expected 1 0 00 0 0 0 0",
                     a_in_ready, a_sel, a_mux_in, a_ser_valid, a_busy, a_ser_last, a_ser_bit);
        end
        nvec++;
        if (b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_mux_in !== '0 || b_ser_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_d3: in_ready=%b busy=%b mux_in=%h valid=%b expected 1 0 00 0",
                     b_in_ready, b_busy, b_mux_in, b_ser_valid);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        nvec++;
        if (a_busy !== 1'b0 || a_mux_in !== '0 || a_in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release: busy=%b mux_in=%h in_ready=%b expected 0 00 1",
                     a_busy, a_mux_in, a_in_ready);
        end
    endtask

    task automatic test_basic_scan();
        select_dut(1'b0);
        scan_word(8'b1010_1010, 1, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_backpressure();
        select_dut(1'b0);
        scan_word(8'b1010_1010, 1, 3, 4, 1'b0, 8'h00);
    endtask

    task automatic test_dwell_busy_ignore();
        select_dut(1'b1);
        scan_word(8'h55, 3, -1, 0, 1'b1, 8'hFF);
        scan_word(8'hFF, 3, -1, 0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_scan();
        select_dut(1'b0);
        ser_ready = 1'b1;
        in_data   = 8'hAA;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if (a_ser_last !== 1'b0 || a_sel !== SEL_W'(k)) begin
                nerr++;
                $display("FAIL pre_abort cycle %0d: last=%b sel=%0d expected 0 %0d", k, a_ser_last, a_sel, k);
            end
            @(negedge clk);
        end
        nvec++;
        if (a_sel !== 3'd5 || a_ser_valid !== 1'b1) begin
            nerr++;
            $display("FAIL abort_point: sel=%0d valid=%b expected 5 1", a_sel, a_ser_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (a_in_ready !== 1'b1 || a_sel !== '0 || a_mux_in !== '0 || a_ser_valid !== 1'b0 ||
            a_ser_last !== 1'b0 || a_busy !== 1'b0 || a_ser_bit !== 1'b0) begin
            nerr++;
            $display("FAIL abort_reset: in_ready=%b sel=%0d mux_in=%h valid=%b last=%b busy=%b bit=%b expected 1 0 00 0 0 0 0",
                     a_in_ready, a_sel, a_mux_in, a_ser_valid, a_ser_last, a_busy, a_ser_bit);
        end
        rst = 1'b0;
        @(negedge clk);
        scan_word(8'h3C, 1, -1, 0, 1'b0, 8'h00);
    endtask

`ifdef MUX_SCAN_PARITY_EN
    task automatic test_parity();
        select_dut(1'b0);
        scan_word(8'hAA, 1, -1, 0, 1'b0, 8'h00);
        scan_word(8'h07, 1, -1, 0, 1'b0, 8'h00);
    endtask
`endif

    initial begin
        which     = 1'b0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_dwell_busy_ignore();
        test_reset_mid_scan();
`ifdef MUX_SCAN_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for an 8:1 bit-select mux.
- Accepts a parallel word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select 0..DATA_W-1 once per bit period, LSB first.
- Presents the selected bit as a serial stream with valid/ready/last; serialises one word per transaction.

Parameters:
SEL_W, 3, select width; DATA_W = 2**SEL_W (8 by default) is a derived localparam.
DWELL, 1, clock cycles each select value is held before its bit is offered (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  DATA_W  parallel word to scan
in_valid  input  1  in_data valid
in_ready  output  1  sequencer idle, can accept a word
mux_in  output  DATA_W  held word driven to the mux data inputs
sel  output  SEL_W  mux select
ser_bit  output  1  currently selected bit, equal to mux_in[sel]
ser_valid  output  1  ser_bit offered downstream
ser_ready  input  1  downstream accepts ser_bit
ser_last  output  1  qualifies the final beat of a word
busy  output  1  a word is being scanned

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, sel=0, mux_in=0, dwell_cnt=0, ser_valid=0, ser_last=0, busy=0, ser_bit=0. in_ready=1 in the first cycle after reset.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_data into mux_in, sel=0, dwell_cnt=0, go to SCAN.
  - busy rises the following cycle.
- State SCAN:
  - in_ready=0.
  - dwell_cnt counts up to DWELL-1 and then saturates.
  - ser_valid=1 only while dwell_cnt==DWELL-1.
- Beat transfer:
  - A beat transfers on ser_valid&&ser_ready.
  - On transfer: dwell_cnt clears; sel increments, unless this is the last beat.
- Stall: ser_ready=0 with ser_valid=1 holds sel, ser_bit and ser_valid stable. No bit is skipped or repeated.
- Last beat:
  - ser_last=ser_valid&&(sel==DATA_W-1).
  - On its transfer go to IDLE; sel returns to 0; mux_in is retained; busy falls.
- Latency (DWELL=1, ser_ready=1):
  - First beat is offered 1 cycle after acceptance.
  - Last beat is offered DATA_W cycles after acceptance.
  - in_ready reasserts the cycle after the last beat.
  - Minimum word period is DATA_W*DWELL+1 cycles.
- sel never wraps within a word; it is only ever 0..DATA_W-1.
- in_valid while busy is ignored. in_data may change freely while busy because the word is captured only at acceptance.
- ser_bit is a combinational select of mux_in by sel and contains no extra register.
- rst mid-scan aborts the word: all outputs take their reset values next cycle and no ser_last is issued.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined:
  - After the bit at sel=DATA_W-1 transfers, one extra PARITY beat follows with ser_bit = XOR of mux_in (even parity).
  - The PARITY beat uses the same DWELL and handshake as data beats.
  - sel stays at DATA_W-1 during the PARITY beat.
  - ser_last moves to the PARITY beat only.
  - Word period becomes (DATA_W+1)*DWELL+1 cycles.
- Undefined: no PARITY state; exactly DATA_W beats per word.

Decomposition:
- Shared package mux_scan_pkg contains:
  - state enum IDLE/SCAN/PARITY;
  - localparam DATA_W derivation;
  - dwell counter width function clog2(DWELL+1).
- One natural sub-module: sel_mux8, a combinational DATA_W:1 select producing ser_bit from mux_in and sel.
- The FSM and counters stay in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold rst 2 cycles with in_valid=1.
   - Response: in_ready=1, sel=0, mux_in=0, ser_valid=0, busy=0; no word accepted.
2. Basic scan:
   - Stimulus: in_data=8'b10101010, DWELL=1, ser_ready=1, accepted at cycle T.
   - Response: over T+1..T+8, sel=0..7 and ser_bit=0,1,0,1,0,1,0,1; ser_last only at T+8; in_ready=1 at T+9.
3. Backpressure:
   - Stimulus: same word; drop ser_ready for 4 cycles while sel=3.
   - Response: sel=3, ser_bit=1 and ser_valid=1 held for all 4 cycles; full 8-bit sequence intact; last beat delayed 4 cycles.
4. Dwell and busy-ignore:
   - Stimulus: DWELL=3, in_data=8'h55; pulse in_valid with 8'hFF mid-scan.
   - Response: ser_valid high every 3rd cycle; beats 1,0,1,0,1,0,1,0; 8'hFF is not accepted until in_ready returns, then streams eight 1s.
5. Reset mid-scan:
   - Stimulus: assert rst while sel=5.
   - Response: next cycle all outputs at reset values; ser_last never seen for the aborted word; the next word scans from sel=0.
6. Parity (MUX_SCAN_PARITY_EN defined):
   - Stimulus: send 8'hAA, then 8'h07.
   - Response: 9th beat ser_bit=0 for 8'hAA and 1 for 8'h07; ser_last only on the 9th beat; sel=7 during the parity beat.
